// File: rtl/gpu_pkg.sv
// Shared GPU definitions: fetcher FSM states, the no-sprite tile code and RGB565 word helpers.
package gpu_pkg;

   localparam int          RGB565_W       = 16;
   localparam int          TILE_NUM_W     = 16;
   localparam int          TILE_WORD_W    = 2 * RGB565_W;
   localparam logic [15:0] NO_SPRITE_TILE = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_OUTPUT = 2'd2
   } fetch_state_t;

   // A tile word packs two pixels; the even pixel sits in the low half.
   function automatic logic [RGB565_W-1:0] pick_pixel(input logic [TILE_WORD_W-1:0] word,
                                                      input logic                    odd);
      return odd ? word[TILE_WORD_W-1:RGB565_W] : word[RGB565_W-1:0];
   endfunction

endpackage

// File: rtl/tile_word_cache.sv
// One-word tile-memory cache (address + data + valid), present only when TILE_FETCH_CACHE_EN is defined.
module tile_word_cache
   import gpu_pkg::*;
#(
   parameter int ADDR_W = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      lookup_addr,
   input  logic                   inval,
   input  logic                   fill_en,
   input  logic [ADDR_W-1:0]      fill_addr,
   input  logic [TILE_WORD_W-1:0] fill_data,
   output logic                   hit,
   output logic [TILE_WORD_W-1:0] hit_data
);

`ifdef TILE_FETCH_CACHE_EN
   logic                   valid;
   logic [ADDR_W-1:0]      word_addr;
   logic [TILE_WORD_W-1:0] word_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (inval) begin
         valid <= 1'b0;
      end else if (fill_en) begin
         valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         word_addr <= fill_addr;
         word_data <= fill_data;
      end
   end

   // An invalidate arriving with a lookup must already count as a miss.
   assign hit      = valid && (word_addr == lookup_addr) && !inval;
   assign hit_data = word_data;
`else
   logic unused_cache_inputs;
   assign unused_cache_inputs = ^{clk, rst_n, lookup_addr, inval, fill_en, fill_addr, fill_data};
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

endmodule

// File: rtl/tile_pixel_fetcher.sv
// Per-pixel tile colour fetcher: address generation, tile-memory fetch FSM and transparency handling.
// Optional one-word cache enabled by defining TILE_FETCH_CACHE_EN.
module tile_pixel_fetcher
   import gpu_pkg::*;
#(
   parameter int          TILE_SIZE_LOG2    = 3,
   parameter int          TILE_ADDR_W       = 20,
   parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F
) (
   input  logic                   gpu_clk,
   input  logic                   rst_n,
   input  logic [TILE_NUM_W-1:0]  tile_number,
   input  logic [7:0]             offset_x,
   input  logic [7:0]             offset_y,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   tile_req,
   output logic [TILE_ADDR_W-1:0] tile_addr,
   input  logic                   tile_ack,
   input  logic [TILE_WORD_W-1:0] tile_rdata,
   input  logic                   inval,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RGB565_W-1:0]    out_color,
   output logic                   out_transparent
);

   localparam int ROW_SHIFT  = TILE_SIZE_LOG2 - 1;
   localparam int TILE_SHIFT = 2 * TILE_SIZE_LOG2 - 1;

   fetch_state_t              state;
   logic [TILE_SIZE_LOG2-1:0] ox_m, oy_m;
   logic [TILE_ADDR_W-1:0]    lookup_addr;
   logic                      hit;
   logic [TILE_WORD_W-1:0]    hit_data;
   logic                      pix_odd;
   logic                      stale;
   logic                      fill_en;

   logic unused_offset_bits;
   assign unused_offset_bits = ^{offset_x[7:TILE_SIZE_LOG2], offset_y[7:TILE_SIZE_LOG2]};

   assign ox_m = offset_x[TILE_SIZE_LOG2-1:0];
   assign oy_m = offset_y[TILE_SIZE_LOG2-1:0];

   // Arithmetic in TILE_ADDR_W bits gives the modulo-2**TILE_ADDR_W wrap for free.
   assign lookup_addr = (TILE_ADDR_W'(tile_number) << TILE_SHIFT)
                      + (TILE_ADDR_W'(oy_m) << ROW_SHIFT)
                      + TILE_ADDR_W'(ox_m >> 1);

   // A word whose memory was rewritten mid-fetch serves this pixel but is never cached.
   assign fill_en = (state == ST_FETCH) && tile_ack && !stale && !inval;

   tile_word_cache #(
      .ADDR_W(TILE_ADDR_W)
   ) u_cache (
      .clk        (gpu_clk),
      .rst_n      (rst_n),
      .lookup_addr(lookup_addr),
      .inval      (inval),
      .fill_en    (fill_en),
      .fill_addr  (tile_addr),
      .fill_data  (tile_rdata),
      .hit        (hit),
      .hit_data   (hit_data)
   );

   function automatic logic [RGB565_W:0] shade(input logic [RGB565_W-1:0] pix);
      if (pix == TRANSPARENT_COLOR) return {1'b1, {RGB565_W{1'b0}}};
      return {1'b0, pix};
   endfunction

   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         in_ready        <= 1'b0;
         tile_req        <= 1'b0;
         tile_addr       <= '0;
         out_valid       <= 1'b0;
         out_color       <= '0;
         out_transparent <= 1'b0;
         pix_odd         <= 1'b0;
         stale           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  pix_odd  <= ox_m[0];
                  if (tile_number == NO_SPRITE_TILE) begin
                     out_valid                    <= 1'b1;
                     {out_transparent, out_color} <= {1'b1, {RGB565_W{1'b0}}};
                     state                        <= ST_OUTPUT;
                  end else if (hit) begin
                     out_valid                    <= 1'b1;
                     {out_transparent, out_color} <= shade(pick_pixel(hit_data, ox_m[0]));
                     state                        <= ST_OUTPUT;
                  end else begin
                     tile_req  <= 1'b1;
                     tile_addr <= lookup_addr;
                     stale     <= 1'b0;
                     state     <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (inval) stale <= 1'b1;
               if (tile_ack) begin
                  tile_req                     <= 1'b0;
                  out_valid                    <= 1'b1;
                  {out_transparent, out_color} <= shade(pick_pixel(tile_rdata, pix_odd));
                  state                        <= ST_OUTPUT;
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_pixel_fetcher.sv
// Directed bench for tile_pixel_fetcher with a pixel-level reference model; honours TILE_FETCH_CACHE_EN.
module tb_tile_pixel_fetcher;

   localparam int TL2      = 3;
   localparam int AW       = 20;
   localparam int TILE_MUL = 2 ** (2 * TL2 - 1);
   localparam int ROW_MUL  = 2 ** (TL2 - 1);
   localparam int EDGE     = 2 ** TL2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   tile_number = '0;
   logic [7:0]    offset_x = '0;
   logic [7:0]    offset_y = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          tile_req;
   logic [AW-1:0] tile_addr;
   logic          tile_ack = 1'b0;
   logic [31:0]   tile_rdata = '0;
   logic          inval = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_color;
   logic          out_transparent;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0]   exp_color = '0;
   logic          exp_trans = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   bit            mc_valid = 1'b0;
   logic [AW-1:0] mc_addr = '0;
   logic [31:0]   mc_data = '0;

   always #5 clk = ~clk;

   tile_pixel_fetcher dut (
      .gpu_clk        (clk),
      .rst_n          (rst_n),
      .tile_number    (tile_number),
      .offset_x       (offset_x),
      .offset_y       (offset_y),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .tile_req       (tile_req),
      .tile_addr      (tile_addr),
      .tile_ack       (tile_ack),
      .tile_rdata     (tile_rdata),
      .inval          (inval),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_color      (out_color),
      .out_transparent(out_transparent)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [AW-1:0] model_addr(input int tile, input int ox, input int oy);
      longint v;
      v = longint'(tile) * TILE_MUL + longint'(oy % EDGE) * ROW_MUL + longint'((ox % EDGE) / 2);
      return AW'(v % (longint'(1) << AW));
   endfunction

   function automatic bit model_hit(input logic [AW-1:0] a);
`ifdef TILE_FETCH_CACHE_EN
      return mc_valid && (mc_addr == a);
`else
      return (a != a);
`endif
   endfunction

   // Continuous comparison against the model whenever outputs carry meaning
   always @(negedge clk) begin
      if (out_valid) begin
         chk("model_color", 32'(out_color), 32'(exp_color));
         chk("model_transparent", 32'(out_transparent), 32'(exp_trans));
      end
      if (tile_req) chk("model_addr", 32'(tile_addr), 32'(exp_addr));
   end

   task automatic lookup(input string tag, input logic [15:0] tile, input logic [7:0] ox,
                         input logic [7:0] oy, input logic [31:0] word, input bit inval_accept,
                         input bit inval_fetch, input int hold, input logic [AW-1:0] lit_addr,
                         input logic [15:0] lit_color, input logic lit_trans);
      int n;
      bit nospr, miss;
      logic [31:0] used;
      logic [15:0] pix, held_color;
      logic held_trans;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      nospr    = (tile == 16'hFFFF);
      exp_addr = model_addr(int'(tile), int'(ox), int'(oy));
      miss     = !nospr && (inval_accept || !model_hit(exp_addr));
      used     = miss ? word : mc_data;
      pix      = ((ox % 2) == 1) ? used[31:16] : used[15:0];
      if (nospr || pix == 16'hF81F) begin
         exp_color = 16'h0;
         exp_trans = 1'b1;
      end else begin
         exp_color = pix;
         exp_trans = 1'b0;
      end
      tile_number = tile;
      offset_x    = ox;
      offset_y    = oy;
      in_valid    = 1'b1;
      inval       = inval_accept;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inval    = 1'b0;
      if (inval_accept) mc_valid = 1'b0;
      @(negedge clk);
      chk({tag, " tile_req"}, 32'(tile_req), 32'(miss));
      chk({tag, " out_valid_early"}, 32'(out_valid), 32'(!miss));
      if (miss) begin
         chk({tag, " tile_addr"}, 32'(tile_addr), 32'(lit_addr));
         if (inval_fetch) begin
            inval = 1'b1;
            @(posedge clk);
            #1;
            inval    = 1'b0;
            mc_valid = 1'b0;
         end
         @(negedge clk);
         chk({tag, " tile_req_held"}, 32'(tile_req), 32'd1);
         tile_ack   = 1'b1;
         tile_rdata = word;
         @(posedge clk);
         #1;
         tile_ack   = 1'b0;
         tile_rdata = $urandom;
         @(negedge clk);
         chk({tag, " tile_req_drop"}, 32'(tile_req), 32'd0);
         chk({tag, " out_valid_after_ack"}, 32'(out_valid), 32'd1);
         if (!inval_fetch) begin
            mc_valid = 1'b1;
            mc_addr  = exp_addr;
            mc_data  = word;
         end
      end
      chk({tag, " color"}, 32'(out_color), 32'(lit_color));
      chk({tag, " transparent"}, 32'(out_transparent), 32'(lit_trans));
      held_color = out_color;
      held_trans = out_transparent;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, " hold_color"}, {15'd0, out_transparent, out_color}, {15'd0, held_trans, held_color});
         chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, " out_valid_clear"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst tile_req", 32'(tile_req), 32'd0);
      chk("rst tile_addr", 32'(tile_addr), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_color", 32'(out_color), 32'd0);
      chk("rst out_transparent", 32'(out_transparent), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst release in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("first in_ready", 32'(in_ready), 32'd1);

      lookup("miss_odd", 16'd5, 8'd3, 8'd2, 32'hBEEF1234, 0, 0, 0, 20'h000A9, 16'hBEEF, 1'b0);
      lookup("same_word_even", 16'd5, 8'd2, 8'd2, 32'hBEEF1234, 0, 0, 0, 20'h000A9, 16'h1234, 1'b0);
      lookup("no_sprite", 16'hFFFF, 8'd7, 8'd1, 32'h55555555, 0, 0, 0, 20'h0, 16'h0000, 1'b1);
      lookup("transparent_hold", 16'd1, 8'd0, 8'd0, 32'h0000F81F, 0, 0, 5, 20'h00020, 16'h0000, 1'b1);
      lookup("refill", 16'd5, 8'd2, 8'd2, 32'hBEEF1234, 0, 0, 0, 20'h000A9, 16'h1234, 1'b0);
      lookup("repeat", 16'd5, 8'd2, 8'd2, 32'hBEEF1234, 0, 0, 0, 20'h000A9, 16'h1234, 1'b0);
      lookup("inval_lookup", 16'd5, 8'd2, 8'd2, 32'hCAFE5678, 1, 0, 0, 20'h000A9, 16'h5678, 1'b0);
      lookup("inval_fetch", 16'd2, 8'd5, 8'd7, 32'h12345678, 0, 1, 0, 20'h0005E, 16'h1234, 1'b0);
      lookup("after_inval", 16'd2, 8'd5, 8'd7, 32'h0F0F00FF, 0, 0, 0, 20'h0005E, 16'h0F0F, 1'b0);
      lookup("wrap_mask", 16'hFFFE, 8'hFF, 8'hFF, 32'hF81F0000, 0, 0, 0, 20'hFFFDF, 16'h0000, 1'b1);

      // Reset in the middle of a fetch, then a late acknowledge
      tile_number = 16'd3;
      offset_x    = 8'd0;
      offset_y    = 8'd0;
      in_valid    = 1'b1;
      exp_addr    = model_addr(3, 0, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midfetch tile_req", 32'(tile_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midfetch rst tile_req", 32'(tile_req), 32'd0);
      chk("midfetch rst out_valid", 32'(out_valid), 32'd0);
      chk("midfetch rst in_ready", 32'(in_ready), 32'd0);
      mc_valid = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      tile_ack   = 1'b1;
      tile_rdata = 32'h11112222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ack out_valid", 32'(out_valid), 32'd0);
         chk("late_ack tile_req", 32'(tile_req), 32'd0);
      end
      tile_ack = 1'b0;
      chk("late_ack in_ready", 32'(in_ready), 32'd1);

      lookup("post_reset", 16'hFFFE, 8'hFF, 8'hFF, 32'hABCD0001, 0, 0, 0, 20'hFFFDF, 16'hABCD, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tile_pixel_fetcher.md
TILE_PIXEL_FETCHER -- requirements
Module: tile_pixel_fetcher

Interface
REQ-001 SHALL have parameter TILE_SIZE_LOG2, default 3, tile edge = 2**TILE_SIZE_LOG2 pixels (8x8).
REQ-002 SHALL have parameter TILE_ADDR_W, default 20, width of the tile-memory word address.
REQ-003 SHALL have parameter TRANSPARENT_COLOR, default 16'hF81F, the RGB565 value treated as see-through.
REQ-004 SHALL have port gpu_clk, input, 1, the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have ports tile_number, input, 16; offset_x, input, 8; offset_y, input, 8; the sprite lookup result per pixel (16'hFFFF = no sprite).
REQ-007 SHALL have ports in_valid, input, 1, and in_ready, output, 1, the input handshake.
REQ-008 SHALL have ports tile_req, output, 1; tile_addr, output, TILE_ADDR_W; tile_ack, input, 1; tile_rdata, input, 32; the tile-memory read port (two RGB565 pixels per word, even pixel in [15:0]).
REQ-009 SHALL have port inval, input, 1, single-cycle pulse, the CPU has rewritten tile memory.
REQ-010 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_color, output, 16; out_transparent, output, 1.

Function
REQ-011 SHALL mask offset_x/offset_y to TILE_SIZE_LOG2 bits before use.
REQ-012 SHALL form word address = tile_number*2**(2*TILE_SIZE_LOG2-1) + oy*2**(TILE_SIZE_LOG2-1) + (ox>>1), truncated modulo 2**TILE_ADDR_W.
REQ-013 SHALL implement FSM IDLE -> (hit or tile 16'hFFFF) OUTPUT; IDLE -> (miss) FETCH -> (tile_ack) OUTPUT -> (out_ready) IDLE.
REQ-014 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both high.
REQ-015 SHALL, on a miss, assert tile_req with a stable tile_addr from the cycle after acceptance until the cycle tile_ack is sampled high; tile_rdata is valid in the ack cycle.
REQ-016 SHALL assert out_valid the cycle after acceptance (hit/no-sprite) or the cycle after tile_ack (miss), holding out_color and out_transparent stable until out_ready.
REQ-017 SHALL select tile_rdata[31:16] for odd ox, [15:0] for even ox.
REQ-018 SHALL, for tile_number 16'hFFFF, issue no fetch, leave the cache unchanged and output out_color=0, out_transparent=1.
REQ-019 SHALL output out_transparent=1 and out_color=0 when the selected pixel equals TRANSPARENT_COLOR.
REQ-020 SHALL, when inval coincides with a lookup, treat that lookup as a miss; inval during FETCH invalidates the word being fetched after it is used for the current pixel.
REQ-021 SHALL keep tile_req low, ignoring tile_ack, outside FETCH.

Reset
REQ-022 SHALL while rst_n low force FSM IDLE, in_ready=0, tile_req=0, tile_addr=0, out_valid=0, out_color=0, out_transparent=0, cache invalid.
REQ-023 SHALL abandon any in-flight fetch on reset; a late tile_ack after reset is ignored.
REQ-024 SHALL raise in_ready the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL, with TILE_FETCH_CACHE_EN defined, hold a one-word cache (address + data + valid) filled on every completed fetch and consulted on every lookup.
REQ-026 SHALL, without TILE_FETCH_CACHE_EN, treat every non-16'hFFFF lookup as a miss; inval is ignored and cache storage is not synthesised.

Structure
REQ-027 SHALL place FSM state encoding, NO_SPRITE_TILE = 16'hFFFF and RGB565 width in shared package gpu_pkg.
REQ-028 SHALL factor the cache into sub-module tile_word_cache (lookup, fill, invalidate).

Verification
REQ-029 SHALL check: reset, then tile 5, ox 3, oy 2 -> tile_req, tile_addr=0xA9; ack with 0xBEEF1234 -> next cycle out_color=0xBEEF, out_transparent=0.
REQ-030 SHALL check (cache on): then tile 5, ox 2, oy 2 -> no tile_req, out_valid next cycle, out_color=0x1234.
REQ-031 SHALL check: tile 0xFFFF, any offsets -> no tile_req, out_valid next cycle, out_color=0, out_transparent=1.
REQ-032 SHALL check: word 0x0000F81F, ox 0 -> out_transparent=1, out_color=0; out_ready held low 5 cycles -> outputs stable, in_ready=0.
REQ-033 SHALL check: inval pulsed with repeat of REQ-030 lookup -> tile_req reissued at 0xA9.
REQ-034 SHALL check: rst_n low mid-FETCH -> tile_req=0 and out_valid=0 at once; late tile_ack produces no output.
